multicycle_control_fsm: RTL
===========================

Name: multicycle_control_fsm

Overview:
- Multi-cycle successor to the single-cycle combinational MIPS control decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB over a shared memory port with a req/ready handshake.
- Adds parametrised wait-state timeout, optional bne support, a sticky error state and a retired-instruction counter.
- Sits between the instruction register (opcode/funct) and the multi-cycle datapath muxes and enables.

Parameters:
- TIMEOUT, 16: max wait cycles on mem_ready before ERROR; 0 disables the timeout.
- EN_BNE, 1: 1 decodes bne (opcode 0x05); 0 treats 0x05 as illegal.
- CNT_W, 32: width of the retired-instruction counter.
- ALUSRC_W, 2: width of the alusrc select.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  6  IR[31:26], stable from DECODE until return to FETCH.
- funct  in  6  IR[5:0].
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request.
- iord  out  1  0 = instruction address (PC), 1 = data address (ALUOut).
- memread  out  1  read strobe.
- memwrite  out  1  write strobe.
- irwrite  out  1  load IR.
- pcwrite  out  1  unconditional PC update.
- branch  out  1  conditional PC update on zero.
- branch_ne  out  1  invert branch condition (bne).
- jump  out  1  PC source = jump target.
- regdest  out  1  rd (1) or rt (0).
- regwrite  out  1  register file write.
- memtoreg  out  1  writeback from MDR.
- alusrc  out  ALUSRC_W  0 = reg, 1 = imm, 2 = shamt.
- state  out  3  current state encoding.
- error  out  1  sticky fault flag.
- instr_retired  out  CNT_W  retired-instruction count.

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERROR=6.
- Reset (asynchronous): state=IDLE, wait counter=0, instr_retired=0, error=0. All strobes are Moore-decoded from state and read 0 in IDLE.
- IDLE: all outputs 0; moves to FETCH on the next edge unconditionally.
- FETCH:
  - Outputs: mem_req=1, memread=1, iord=0.
  - If mem_ready: irwrite=1 and pcwrite=1 (PC+4) in the same cycle, then go to DECODE.
  - Otherwise stay and increment the wait counter.
- DECODE, one cycle:
  - j (0x02): pcwrite=1, jump=1, retire, go to FETCH.
  - R-type (0x00), addi (0x08), lw (0x23), sw (0x2B), beq (0x04), and bne (0x05) if EN_BNE: go to EXEC.
  - Any other opcode: go to ERROR.
- EXEC, one cycle:
  - R-type: alusrc=2 when funct is 0x00 or 0x02, else 0; go to WB.
  - addi, lw, sw: alusrc=1; addi goes to WB, lw/sw go to MEM.
  - beq: branch=1, alusrc=0. bne: additionally branch_ne=1. Both retire and go to FETCH.
- MEM:
  - Outputs: mem_req=1, iord=1; memread=1 for lw, memwrite=1 for sw. Strobes are held until mem_ready.
  - On mem_ready: lw goes to WB; sw retires and goes to FETCH.
- WB, one cycle:
  - regwrite=1; regdest=1 for R-type; memtoreg=1 for lw.
  - Retire, go to FETCH.
- Latency with zero wait states: j=2, beq/bne=3, sw=4, R/addi=4, lw=5 cycles. Each wait cycle in FETCH or MEM adds 1.
- Wait counter:
  - Clears on entry to FETCH/MEM and on any mem_ready.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT with mem_ready low, go to ERROR on the next edge.
  - mem_ready arriving in that same cycle wins; no error.
- ERROR:
  - All strobes 0, error=1.
  - Absorbing; only reset exits.
  - mem_ready is ignored.
- instr_retired: +1 on the edge leaving the last state of each instruction. Wraps modulo 2^CNT_W; it does not saturate.
- Reset mid-operation (including mid-MEM with memwrite high): strobes drop asynchronously and the pending access is abandoned.
- mem_ready outside FETCH/MEM is ignored.

Test Plan:
- Reset, then lw (0x23) with mem_ready tied 1 → state 0→1→2→3→4→5→1. regwrite=memtoreg=1 only in WB; instr_retired=1 after 6 edges.
- sw (0x2B), mem_ready low 3 cycles in MEM → memwrite=1 for 4 cycles, no regwrite, retire on the ready cycle, back to FETCH.
- beq and bne with EN_BNE=1 → EXEC asserts branch=1 (branch_ne=1 for bne) for exactly 1 cycle. With EN_BNE=0, bne → ERROR, error=1.
- Illegal opcode 0x3F → DECODE→ERROR, all strobes 0, error held across 20 cycles of mem_ready toggling.
- TIMEOUT=4, mem_ready held 0 in FETCH → ERROR after 4 wait cycles. Repeat with mem_ready=1 on the 4th wait cycle → DECODE, no error.
- Reset asserted mid-MEM of sw → memwrite=0 immediately, state=0, instr_retired=0. Set CNT_W=4: 16 j instructions → counter wraps to 0.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control sequencer: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB over a shared req/ready memory port. It has a
// wait-state timeout, optional bne decode, a sticky ERROR state and a
// retired-instruction counter.
module multicycle_control_fsm #(
  parameter int unsigned TIMEOUT  = 16,
  parameter bit          EN_BNE   = 1'b1,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned ALUSRC_W = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                iord,
  output logic                memread,
  output logic                memwrite,
  output logic                irwrite,
  output logic                pcwrite,
  output logic                branch,
  output logic                branch_ne,
  output logic                jump,
  output logic                regdest,
  output logic                regwrite,
  output logic                memtoreg,
  output logic [ALUSRC_W-1:0] alusrc,
  output logic [2:0]          state,
  output logic                error,
  output logic [CNT_W-1:0]    instr_retired
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    ERROR  = 3'd6
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [ALUSRC_W-1:0] SRC_REG   = '0;
  localparam logic [ALUSRC_W-1:0] SRC_IMM   = ALUSRC_W'(1);
  localparam logic [ALUSRC_W-1:0] SRC_SHAMT = ALUSRC_W'(2);

  localparam int unsigned     WAIT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit              TO_EN     = (TIMEOUT != 0);

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               retire;

  // Opcode classes; the IR holds the opcode steady from DECODE onwards.
  logic is_r, is_j, is_beq, is_bne, is_addi, is_lw, is_sw, is_legal, is_shift;
  logic timed_out;

  assign is_r      = (opcode == OP_R);
  assign is_j      = (opcode == OP_J);
  assign is_beq    = (opcode == OP_BEQ);
  assign is_bne    = EN_BNE && (opcode == OP_BNE);
  assign is_addi   = (opcode == OP_ADDI);
  assign is_lw     = (opcode == OP_LW);
  assign is_sw     = (opcode == OP_SW);
  assign is_legal  = is_r | is_addi | is_lw | is_sw | is_beq | is_bne;
  assign is_shift  = (funct == 6'h00) || (funct == 6'h02);
  // The cycle whose wait would bring the count to TIMEOUT is the last allowed.
  assign timed_out = TO_EN && (wait_q == WAIT_LAST) && !mem_ready;

  assign state         = state_q;
  assign instr_retired = retired_q;

  // State, wait counter and retired counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  // Next-state, wait-counter update and state-decoded control strobes.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    retire    = 1'b0;
    mem_req   = 1'b0;
    iord      = 1'b0;
    memread   = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    pcwrite   = 1'b0;
    branch    = 1'b0;
    branch_ne = 1'b0;
    jump      = 1'b0;
    regdest   = 1'b0;
    regwrite  = 1'b0;
    memtoreg  = 1'b0;
    alusrc    = SRC_REG;
    error     = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
        wait_d  = '0;
      end
      FETCH: begin
        mem_req = 1'b1;
        memread = 1'b1;
        if (mem_ready) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          wait_d  = '0;
          state_d = DECODE;
        end else if (timed_out) begin
          state_d = ERROR;
        end else if (TO_EN) begin
          wait_d = wait_q + 1'b1;
        end
      end
      DECODE: begin
        if (is_j) begin
          pcwrite = 1'b1;
          jump    = 1'b1;
          retire  = 1'b1;
          wait_d  = '0;
          state_d = FETCH;
        end else if (is_legal) begin
          state_d = EXEC;
        end else begin
          state_d = ERROR;
        end
      end
      EXEC: begin
        if (is_r) begin
          alusrc  = is_shift ? SRC_SHAMT : SRC_REG;
          state_d = WB;
        end else if (is_addi) begin
          alusrc  = SRC_IMM;
          state_d = WB;
        end else if (is_lw || is_sw) begin
          alusrc  = SRC_IMM;
          wait_d  = '0;
          state_d = MEM;
        end else if (is_beq || is_bne) begin
          branch    = 1'b1;
          branch_ne = is_bne;
          retire    = 1'b1;
          wait_d    = '0;
          state_d   = FETCH;
        end else begin
          state_d = ERROR;
        end
      end
      MEM: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        memread  = is_lw;
        memwrite = is_sw;
        if (mem_ready) begin
          wait_d = '0;
          if (is_lw) begin
            state_d = WB;
          end else begin
            retire  = 1'b1;
            state_d = FETCH;
          end
        end else if (timed_out) begin
          state_d = ERROR;
        end else if (TO_EN) begin
          wait_d = wait_q + 1'b1;
        end
      end
      WB: begin
        regwrite = 1'b1;
        regdest  = is_r;
        memtoreg = is_lw;
        retire   = 1'b1;
        wait_d   = '0;
        state_d  = FETCH;
      end
      ERROR: begin
        error = 1'b1;
      end
      default: begin
        state_d = ERROR;
      end
    endcase

    retired_d = retired_q + CNT_W'(retire);
  end

endmodule
